// File: rtl/metaframe_framer_if.sv
// User-side 64b/67b word stream into the metaframe framer.
// The source drives data/header/valid; the framer answers with ready.
interface metaframe_framer_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] USER_DATA;
    logic [1:0]        USER_HEADER;
    logic              USER_VALID;
    logic              USER_READY;

    modport master (
        output USER_DATA,
        output USER_HEADER,
        output USER_VALID,
        input  USER_READY
    );

    modport slave (
        input  USER_DATA,
        input  USER_HEADER,
        input  USER_VALID,
        output USER_READY
    );
endinterface

// File: rtl/metaframe_framer.sv
// Per-lane Interlaken TX metaframe sequencer feeding the lane scrambler:
// Sync, Scrambler-State, Skip, METAFRAME_LEN-4 payload slots, Diagnostic.
module metaframe_framer #(
    parameter int          TX_DATA_WIDTH = 64,
    parameter int          METAFRAME_LEN = 2048,
    parameter logic [63:0] SYNC_WORD     = 64'h78f678f678f678f6,
    parameter logic [63:0] SCRAM_WORD    = 64'h2800000000000000,
    parameter logic [63:0] SKIP_WORD     = 64'h1e1e1e1e1e1e1e1e,
    parameter logic [63:0] IDLE_WORD     = 64'h0700000000000000
) (
    input  logic                     USER_CLK,
    input  logic                     SYSTEM_RESET,
    input  logic                     ENABLE,
    input  logic                     TX_PAUSE,
    metaframe_framer_if.slave        user,
    input  logic                     LANE_STATUS,
    input  logic                     LINK_STATUS,
    output logic [TX_DATA_WIDTH-1:0] DATA_OUT,
    output logic [1:0]               HEADER_OUT,
    output logic                     DATA_OUT_VALID,
    output logic                     MF_START
);
    localparam int              SLOT_W    = $clog2(METAFRAME_LEN);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(METAFRAME_LEN - 5);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [1:0]      HDR_CTRL  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SCRAM,
        S_SKIP,
        S_DATA,
        S_DIAG
    } state_t;

    state_t                   state_reg, state_next;
    logic [SLOT_W-1:0]        slot_reg, slot_next;
    logic [TX_DATA_WIDTH-1:0] data_out_reg, data_out_next;
    logic [1:0]               header_out_reg, header_out_next;
    logic                     valid_reg, valid_next;
    logic                     mf_start_reg, mf_start_next;
    logic [TX_DATA_WIDTH-1:0] diag_word;

    // CRC32 field left zero; a downstream stage fills it in.
    assign diag_word = {6'b011001, 24'h0, LANE_STATUS, LINK_STATUS, 32'h0};

    assign user.USER_READY = (state_reg == S_DATA) && !TX_PAUSE && !SYSTEM_RESET;

    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            state_reg      <= S_IDLE;
            slot_reg       <= '0;
            data_out_reg   <= '0;
            header_out_reg <= 2'b00;
            valid_reg      <= 1'b0;
            mf_start_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            slot_reg       <= slot_next;
            data_out_reg   <= data_out_next;
            header_out_reg <= header_out_next;
            valid_reg      <= valid_next;
            mf_start_reg   <= mf_start_next;
        end
    end

    // A paused cycle falls through with everything held and valid low.
    always_comb begin
        state_next      = state_reg;
        slot_next       = slot_reg;
        data_out_next   = data_out_reg;
        header_out_next = header_out_reg;
        valid_next      = 1'b0;
        mf_start_next   = 1'b0;
        if (!TX_PAUSE) begin
            case (state_reg)
                S_IDLE: begin
                    if (ENABLE) begin
                        state_next = S_SYNC;
                    end
                end
                S_SYNC: begin
                    data_out_next   = SYNC_WORD;
                    header_out_next = HDR_CTRL;
                    valid_next      = 1'b1;
                    mf_start_next   = 1'b1;
                    state_next      = S_SCRAM;
                end
                S_SCRAM: begin
                    data_out_next   = SCRAM_WORD;
                    header_out_next = HDR_CTRL;
                    valid_next      = 1'b1;
                    state_next      = S_SKIP;
                end
                S_SKIP: begin
                    data_out_next   = SKIP_WORD;
                    header_out_next = HDR_CTRL;
                    valid_next      = 1'b1;
                    slot_next       = '0;
                    state_next      = S_DATA;
                end
                S_DATA: begin
                    valid_next = 1'b1;
                    if (user.USER_VALID) begin
                        data_out_next   = user.USER_DATA;
                        header_out_next = user.USER_HEADER;
                    end else begin
                        data_out_next   = IDLE_WORD;
                        header_out_next = HDR_CTRL;
                    end
                    if (slot_reg == LAST_SLOT) begin
                        slot_next  = '0;
                        state_next = S_DIAG;
                    end else begin
                        slot_next = slot_reg + SLOT_ONE;
                    end
                end
                S_DIAG: begin
                    data_out_next   = diag_word;
                    header_out_next = HDR_CTRL;
                    valid_next      = 1'b1;
                    state_next      = ENABLE ? S_SYNC : S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign DATA_OUT       = data_out_reg;
    assign HEADER_OUT     = header_out_reg;
    assign DATA_OUT_VALID = valid_reg;
    assign MF_START       = mf_start_reg;
endmodule

// File: tb/tb_metaframe_framer.sv
// Directed bench for metaframe_framer (METAFRAME_LEN=8): expected words are
// queued as each scenario is driven and popped as valid words come out.
module tb_metaframe_framer;
    localparam int          MF_LEN  = 8;
    localparam int          SLOTS   = MF_LEN - 4;
    localparam logic [63:0] SYNC_W  = 64'h78f678f678f678f6;
    localparam logic [63:0] SCRAM_W = 64'h2800000000000000;
    localparam logic [63:0] SKIP_W  = 64'h1e1e1e1e1e1e1e1e;
    localparam logic [63:0] IDLE_W  = 64'h0700000000000000;
    localparam logic [63:0] DPAT    = 64'hd0d0000000000000;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  h;
        logic        mf;
    } exp_t;

    logic        USER_CLK;
    logic        SYSTEM_RESET = 1'b1;
    logic        ENABLE       = 1'b0;
    logic        TX_PAUSE     = 1'b0;
    logic        LANE_STATUS  = 1'b0;
    logic        LINK_STATUS  = 1'b0;
    logic [63:0] DATA_OUT;
    logic [1:0]  HEADER_OUT;
    logic        DATA_OUT_VALID;
    logic        MF_START;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          data_idx = 0;
    int          push_idx = 0;
    int          ready_cnt = 0;
    int          words_since = 0;
    bit          frame_seen = 0;
    bit          prev_pause = 0;
    logic [63:0] held_data = '0;

    metaframe_framer_if #(.DATA_W(64)) user_if ();

    metaframe_framer #(.METAFRAME_LEN(MF_LEN)) dut (
        .USER_CLK       (USER_CLK),
        .SYSTEM_RESET   (SYSTEM_RESET),
        .ENABLE         (ENABLE),
        .TX_PAUSE       (TX_PAUSE),
        .user           (user_if.slave),
        .LANE_STATUS    (LANE_STATUS),
        .LINK_STATUS    (LINK_STATUS),
        .DATA_OUT       (DATA_OUT),
        .HEADER_OUT     (HEADER_OUT),
        .DATA_OUT_VALID (DATA_OUT_VALID),
        .MF_START       (MF_START)
    );

    initial begin
        USER_CLK = 1'b0;
        forever #5 USER_CLK = ~USER_CLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [63:0] d, input logic [1:0] h, input logic mf);
        exp_t e;
        e.d  = d;
        e.h  = h;
        e.mf = mf;
        sb_q.push_back(e);
    endtask

    task automatic push_head();
        push_word(SYNC_W, 2'b10, 1'b1);
        push_word(SCRAM_W, 2'b10, 1'b0);
        push_word(SKIP_W, 2'b10, 1'b0);
    endtask

    task automatic push_data();
        push_word(DPAT | 64'(push_idx), 2'b01, 1'b0);
        push_idx++;
    endtask

    task automatic push_frame(input bit with_data, input logic lane, input logic link);
        push_head();
        for (int s = 0; s < SLOTS; s++) begin
            if (with_data) push_data();
            else push_word(IDLE_W, 2'b10, 1'b0);
        end
        push_word({6'b011001, 24'h0, lane, link, 32'h0}, 2'b10, 1'b0);
    endtask

    // One clock: checks pause rules mid-cycle, then advances the user source on a handshake.
    task automatic tick();
        bit hs;
        @(negedge USER_CLK);
        if (TX_PAUSE) chk("ready_in_pause", 64'(user_if.USER_READY), 64'd0);
        if (prev_pause) begin
            chk("valid_after_pause", 64'(DATA_OUT_VALID), 64'd0);
            chk("hold_after_pause", DATA_OUT, held_data);
        end
        if (user_if.USER_READY) ready_cnt++;
        hs         = user_if.USER_VALID && user_if.USER_READY;
        prev_pause = TX_PAUSE && !SYSTEM_RESET;
        held_data  = DATA_OUT;
        @(posedge USER_CLK);
        #1;
        if (hs) begin
            data_idx++;
            user_if.USER_DATA = DPAT | 64'(data_idx);
        end
    endtask

    always @(negedge USER_CLK) begin
        if (DATA_OUT_VALID) begin
            exp_t e;
            if (MF_START) begin
                if (frame_seen) chk("frame_len", 64'(words_since), 64'(MF_LEN));
                frame_seen  = 1'b1;
                words_since = 0;
            end
            words_since++;
            total++;
            assert (sb_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_underflow observed=%h expected=queued_word", DATA_OUT);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("data_out", DATA_OUT, e.d);
                chk("header_out", 64'(HEADER_OUT), 64'(e.h));
                chk("mf_start", 64'(MF_START), 64'(e.mf));
            end
        end else if (!SYSTEM_RESET) begin
            chk("mf_without_valid", 64'(MF_START), 64'd0);
        end
        if (SYSTEM_RESET) begin
            frame_seen  = 1'b0;
            words_since = 0;
        end
    end

    initial begin
        user_if.USER_DATA   = DPAT;
        user_if.USER_HEADER = 2'b01;
        user_if.USER_VALID  = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_data", DATA_OUT, 64'd0);
        chk("rst_header", 64'(HEADER_OUT), 64'd0);
        chk("rst_valid", 64'(DATA_OUT_VALID), 64'd0);
        chk("rst_mf", 64'(MF_START), 64'd0);
        chk("rst_ready", 64'(user_if.USER_READY), 64'd0);
        SYSTEM_RESET = 1'b0;

        // Two back-to-back frames of user data
        push_frame(1'b1, 1'b0, 1'b0);
        push_frame(1'b1, 1'b0, 1'b0);
        ENABLE             = 1'b1;
        user_if.USER_VALID = 1'b1;
        ready_cnt          = 0;
        repeat (17) tick();
        chk("ready_cycles_2frames", 64'(ready_cnt), 64'd8);

        // Payload slots with no user data become idle words
        push_frame(1'b0, 1'b0, 1'b0);
        user_if.USER_VALID = 1'b0;
        ready_cnt          = 0;
        repeat (8) tick();
        chk("ready_cycles_idle_frame", 64'(ready_cnt), 64'd4);

        // ENABLE dropped in slot 1; diagnostic carries lane=1 link=0
        push_frame(1'b1, 1'b1, 1'b0);
        user_if.USER_VALID = 1'b1;
        repeat (4) tick();
        ENABLE = 1'b0;
        repeat (3) tick();
        LANE_STATUS = 1'b1;
        tick();
        LANE_STATUS = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("idle_after_disable", 64'(DATA_OUT_VALID), 64'd0);
            chk("idle_ready", 64'(user_if.USER_READY), 64'd0);
        end
        chk("sb_empty_after_disable", 64'(sb_q.size()), 64'd0);

        // Pause one cycle in three across two frames; ENABLE released at the second DIAG
        push_frame(1'b1, 1'b0, 1'b0);
        push_frame(1'b1, 1'b0, 1'b0);
        ready_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            ENABLE   = (i < 24);
            TX_PAUSE = ((i % 3) == 2);
            tick();
        end
        TX_PAUSE = 1'b0;
        ENABLE   = 1'b0;
        chk("ready_cycles_paused", 64'(ready_cnt), 64'd8);
        chk("sb_empty_after_pause", 64'(sb_q.size()), 64'd0);

        // Reset in the middle of the payload with a word on offer
        push_head();
        push_data();
        ENABLE = 1'b1;
        repeat (5) tick();
        SYSTEM_RESET = 1'b1;
        ENABLE       = 1'b0;
        #1;
        chk("ready_in_reset", 64'(user_if.USER_READY), 64'd0);
        tick();
        SYSTEM_RESET = 1'b0;
        chk("midrst_data", DATA_OUT, 64'd0);
        chk("midrst_header", 64'(HEADER_OUT), 64'd0);
        chk("midrst_valid", 64'(DATA_OUT_VALID), 64'd0);
        chk("midrst_mf", 64'(MF_START), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_after_reset", 64'(DATA_OUT_VALID), 64'd0);
        end

        // Single restart frame with a one-cycle ENABLE
        push_frame(1'b1, 1'b0, 1'b0);
        ENABLE = 1'b1;
        tick();
        ENABLE = 1'b0;
        repeat (10) tick();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
